reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register scoreboard and register-file write-port arbiter for the pipelined core's decode stage. Tracks destination registers of in-flight long-latency operations (load/mul/div unit) and stalls issue on RAW/WAW hazards. Shares the regfile's single write port between the short (ALU) writeback path and the long unit's completions, with a one-entry hold buffer for port conflicts.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers, x0 hard-wired zero)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1 / issue_rs2  in  ADDR_WIDTH  source registers
- issue_use_rs1 / issue_use_rs2  in  1  the corresponding source is actually read
- issue_rd  in  ADDR_WIDTH  destination register
- issue_reg_write  in  1  instruction writes rd
- issue_long  in  1  instruction dispatches to the long-latency unit
- stall  out  1  combinational; hold decode this cycle (issue is accepted iff issue_valid & ~stall)
- long_busy  out  1  a long op is outstanding (state != IDLE)
- short_we / short_rd / short_data  in  1 / ADDR_WIDTH / DATA_WIDTH  ALU writeback request
- long_done_valid / long_done_data  in  1 / DATA_WIDTH  long-unit result
- long_done_ready  out  1  result accepted this cycle
- rf_we / rf_addr / rf_data  out  1 / ADDR_WIDTH / DATA_WIDTH  regfile write port (combinational)
- fwd_rs1_en / fwd_rs2_en / fwd_data  out  1 / 1 / DATA_WIDTH  bypass of a retiring long result

## Operation
- pending[31:1]: one bit per register; pending[0] is constant 0.
- FSM: IDLE (no long op), WAIT (op in flight, long_rd latched), HOLD (result latched, awaiting port).
- IDLE→WAIT: accepted issue with issue_long. Latch long_rd = issue_rd; set pending[rd] only if issue_reg_write & rd != 0.
- WAIT: long_done_ready = 1. On long_done_valid: if ~short_we, drive port with (long_rd, long_done_data) → IDLE; else latch data into hold buffer → HOLD.
- HOLD: drive port with held result whenever short_we = 0, then → IDLE; remain in HOLD while short_we = 1.
- Port priority: short_we > held/long result. rf_we is suppressed when rf_addr == 0.
- The pending bit clears on the edge at which the long result is written (rf_we from the long path).
- stall = issue_valid & (RAW: used rs1/rs2 is pending | WAW: issue_reg_write & pending[issue_rd] | issue_long & state != IDLE | state == HOLD).
- In IDLE, long_done_valid is ignored (ready = 0). short_we to a pending rd cannot occur, because WAW stalls it; this is a bench assertion.

## Timing
- Reset values: pending = 0, state IDLE, hold buffer cleared. Outputs: stall = 0, long_busy = 0, long_done_ready = 0, rf_we = 0, rf_addr = 0, rf_data = 0, fwd_* = 0.
- Reset mid-operation discards the in-flight op and the held data; the long unit is reset in the same cycle.
- pending is set on the edge after acceptance. A dependent instruction presented the next cycle stalls.
- A long result that meets no conflict is written in its arrival cycle (0-cycle latency). With a conflict it is written on the first cycle in which short_we = 0.
- The cycle in which the long write retires still stalls dependents (unless bypass); they issue on the next cycle.

## Configuration
- REG_SCOREBOARD_BYPASS_EN defined: in the cycle the long result drives rf_we, a source register equal to the retiring rd is not a RAW hazard. The matching fwd_rsN_en = 1 and fwd_data = retiring data; the dependent issues the same cycle.
- Undefined: fwd_* are tied to 0 and the retire-cycle stall applies.

## Structure
- Package reg_scoreboard_pkg: state enum typedef (IDLE/WAIT/HOLD) and the REG_COUNT constant.
- One sub-module, wb_hold_buffer: one-entry data/address register with valid, load, and drain.

## Test plan
- Long op to x5, next instruction reads x5 → stall = 1 until result retires; with bypass, issue in the retire cycle with fwd_rs1_en = 1 and fwd_data = 0xDEADBEEF.
- Long result 0x1234 to x7 coincides with short_we to x3 for 2 cycles → x3 is written first, state HOLD for 2 cycles, x7 = 0x1234 on the 3rd cycle, and pending[7] clears.
- Long op with rd = x0 → pending stays 0, rf_we is never asserted for the result, and long_busy drops after done.
- Second issue_long while in WAIT → stall = 1 until IDLE, then accepted the next cycle.
- WAW: issue writing x9 while x9 is pending → stall = 1; a non-dependent instruction (rs/rd = x1, x2) issues without stall.
- rst asserted in WAIT with pending[4] = 1 → next cycle pending = 0, state IDLE, and a later long_done_valid is ignored.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the decode-stage register scoreboard.
package reg_scoreboard_pkg;

    localparam int REG_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } sb_state_e;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry parking slot for a long-unit result that lost the regfile write port.
module wb_hold_buffer
    import reg_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard + regfile write-port arbiter for decode.
// Optional same-cycle bypass of a retiring long result: REG_SCOREBOARD_BYPASS_EN.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  issue_reg_write,
    input  logic                  issue_long,
    output logic                  stall,
    output logic                  long_busy,
    input  logic                  short_we,
    input  logic [ADDR_WIDTH-1:0] short_rd,
    input  logic [DATA_WIDTH-1:0] short_data,
    input  logic                  long_done_valid,
    input  logic [DATA_WIDTH-1:0] long_done_data,
    output logic                  long_done_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  fwd_rs1_en,
    output logic                  fwd_rs2_en,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    sb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] long_rd_q, long_rd_d;
    logic [REG_COUNT-1:0]  pending_q, pending_d;

    logic                  accept;
    logic                  retire, long_we;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [DATA_WIDTH-1:0] ret_data;
    logic                  hb_load, hb_drain, hb_valid;
    logic [ADDR_WIDTH-1:0] hb_addr;
    logic [DATA_WIDTH-1:0] hb_data;
    logic                  raw1, raw2, waw, byp1, byp2;

    wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .addr_i  (long_rd_q),
        .data_i  (long_done_data),
        .valid_o (hb_valid),
        .addr_o  (hb_addr),
        .data_o  (hb_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            long_rd_q <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            long_rd_q <= long_rd_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        long_rd_d = long_rd_q;
        case (state_q)
            IDLE: if (accept && issue_long) begin
                state_d   = WAIT;
                long_rd_d = issue_rd;
            end
            WAIT: if (long_done_valid) state_d = short_we ? HOLD : IDLE;
            HOLD: if (!short_we)       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Short writeback always owns the port; the long path only retires when it is free.
    always_comb begin
        long_done_ready = (state_q == WAIT);
        long_busy       = (state_q != IDLE);
        hb_load         = (state_q == WAIT) && long_done_valid && short_we;
        hb_drain        = (state_q == HOLD) && hb_valid && !short_we;
        retire          = ((state_q == WAIT) && long_done_valid && !short_we) || hb_drain;
        ret_addr        = (state_q == HOLD) ? hb_addr : long_rd_q;
        ret_data        = (state_q == HOLD) ? hb_data : long_done_data;
        long_we         = retire && (ret_addr != '0);
        rf_we           = 1'b0;
        rf_addr         = '0;
        rf_data         = '0;
        if (short_we) begin
            rf_we   = (short_rd != '0);
            rf_addr = short_rd;
            rf_data = short_data;
        end else if (retire) begin
            rf_we   = long_we;
            rf_addr = ret_addr;
            rf_data = ret_data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (retire)
            pending_d[ret_addr] = 1'b0;
        if (accept && issue_long && issue_reg_write)
            pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

`ifdef REG_SCOREBOARD_BYPASS_EN
    assign byp1     = long_we && issue_valid && issue_use_rs1 && (issue_rs1 == ret_addr);
    assign byp2     = long_we && issue_valid && issue_use_rs2 && (issue_rs2 == ret_addr);
    assign fwd_data = long_we ? ret_data : '0;
`else
    assign byp1     = 1'b0;
    assign byp2     = 1'b0;
    assign fwd_data = '0;
`endif

    assign fwd_rs1_en = byp1;
    assign fwd_rs2_en = byp2;

    assign raw1   = issue_use_rs1 && pending_q[issue_rs1] && !byp1;
    assign raw2   = issue_use_rs2 && pending_q[issue_rs2] && !byp2;
    assign waw    = issue_reg_write && pending_q[issue_rd];
    assign stall  = issue_valid && (raw1 || raw2 || waw ||
                    (issue_long && (state_q != IDLE)) || (state_q == HOLD));
    assign accept = issue_valid && !stall;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Random + directed bench for reg_scoreboard against a behavioural model.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, u1, u2, wr, il, swe, done_v;
    logic [4:0]  rs1, rs2, rd, srd;
    logic [31:0] sdata, done_d;
    logic        stall, busy, ready, rf_we, fwd1, fwd2;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    // model: which registers await a long result, and where the long op is
    bit          pend[32];
    int          m_st;      // 0 none, 1 in flight, 2 result parked
    logic [4:0]  m_rd;
    logic [31:0] m_hd;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(iv), .issue_rs1(rs1), .issue_rs2(rs2),
        .issue_use_rs1(u1), .issue_use_rs2(u2), .issue_rd(rd),
        .issue_reg_write(wr), .issue_long(il),
        .stall(stall), .long_busy(busy),
        .short_we(swe), .short_rd(srd), .short_data(sdata),
        .long_done_valid(done_v), .long_done_data(done_d), .long_done_ready(ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .fwd_rs1_en(fwd1), .fwd_rs2_en(fwd2), .fwd_data(fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr();
        rst = 0; iv = 0; u1 = 0; u2 = 0; wr = 0; il = 0; swe = 0; done_v = 0;
        rs1 = 0; rs2 = 0; rd = 0; srd = 0; sdata = 0; done_d = 0;
    endtask

    function automatic bit retiring();
        return (m_st == 1 && done_v && !swe) || (m_st == 2 && !swe);
    endfunction

    // Compare combinational outputs against the model for the current inputs.
    task automatic settle();
        bit rt, f1, f2, r1, r2, w, est, ewe;
        logic [4:0]  ea;
        logic [31:0] ed, rdat;
        #1;
        rt   = retiring();
        rdat = (m_st == 1) ? done_d : m_hd;
        ewe = 0; ea = 0; ed = 0;
        if (swe) begin
            ewe = (srd != 0); ea = srd; ed = sdata;
        end else if (rt) begin
            ewe = (m_rd != 0); ea = m_rd; ed = rdat;
        end
        f1  = BYP && rt && m_rd != 0 && iv && u1 && rs1 == m_rd;
        f2  = BYP && rt && m_rd != 0 && iv && u2 && rs2 == m_rd;
        r1  = u1 && pend[rs1] && !f1;
        r2  = u2 && pend[rs2] && !f2;
        w   = wr && pend[rd];
        est = iv && (r1 || r2 || w || (il && m_st != 0) || m_st == 2);
        chk("stall", stall, est);
        chk("rf_we", rf_we, ewe);
        chk("rf_addr", rf_addr, ea);
        chk("rf_data", rf_data, ed);
        chk("ready", ready, m_st == 1);
        chk("busy", busy, m_st != 0);
        chk("fwd1", fwd1, f1);
        chk("fwd2", fwd2, f2);
        chk("fwd_data", fwd_data, (BYP && rt && m_rd != 0) ? rdat : 32'h0);
    endtask

    // Advance the model across the coming clock edge, then move to the next negedge.
    task automatic adv();
        bit rt, acc;
        rt  = retiring();
        acc = iv && !stall;
        if (swe && srd != 0 && pend[srd])
            chk("short_to_pending", 1, 0);
        if (rst) begin
            foreach (pend[i]) pend[i] = 0;
            m_st = 0; m_rd = 0; m_hd = 0;
        end else begin
            case (m_st)
                0: if (acc && il) begin
                    m_st = 1; m_rd = rd;
                    if (wr && rd != 0) pend[rd] = 1;
                end
                1: if (done_v) begin
                    if (swe) begin m_st = 2; m_hd = done_d; end
                    else m_st = 0;
                end
                default: if (!swe) m_st = 0;
            endcase
            if (rt) pend[m_rd] = 0;
        end
        @(negedge clk);
    endtask

    task automatic long_op(input logic [4:0] r);
        clr(); iv = 1; il = 1; wr = 1; rd = r;
        settle(); chk("long_accept", stall, 0); adv();
    endtask

    initial begin
        foreach (pend[i]) pend[i] = 0;
        m_st = 0; m_rd = 0; m_hd = 0;
        clr(); rst = 1;
        repeat (2) @(negedge clk);
        settle();
        chk("rst_stall", stall, 0); chk("rst_rf_we", rf_we, 0); chk("rst_busy", busy, 0);
        adv();

        // RAW on x5 until retire (bypass: issue in the retire cycle)
        long_op(5);
        clr(); iv = 1; u1 = 1; rs1 = 5; wr = 1; rd = 6;
        settle(); chk("raw_x5_stall", stall, 1); adv();
        done_v = 1; done_d = 32'hDEADBEEF;
        settle();
        chk("x5_wr_addr", rf_addr, 5); chk("x5_wr_data", rf_data, 32'hDEADBEEF);
        chk("x5_retire_stall", stall, !BYP); chk("x5_fwd1", fwd1, BYP);
        chk("x5_fwd_data", fwd_data, BYP ? 32'hDEADBEEF : 32'h0);
        adv();
        done_v = 0;
        settle(); chk("x5_after_stall", stall, 0); adv();

        // port conflict: x7 parked behind two short writes to x3
        long_op(7);
        clr(); done_v = 1; done_d = 32'h1234; swe = 1; srd = 3; sdata = 32'hAAAA;
        settle(); chk("conf_first_x3", rf_addr, 3); adv();
        clr(); swe = 1; srd = 3; sdata = 32'hBBBB; iv = 1; u1 = 1; rs1 = 1;
        settle(); chk("hold_stall", stall, 1); chk("hold_x3", rf_addr, 3); adv();
        clr();
        settle(); chk("drain_we", rf_we, 1); chk("drain_addr", rf_addr, 7);
        chk("drain_data", rf_data, 32'h1234); adv();
        clr(); iv = 1; u1 = 1; rs1 = 7;
        settle(); chk("x7_cleared", stall, 0); adv();

        // long op to x0
        long_op(0);
        clr(); done_v = 1; done_d = 32'h55;
        settle(); chk("x0_no_we", rf_we, 0); adv();
        clr();
        settle(); chk("x0_idle", busy, 0); adv();

        // second long op while busy
        long_op(10);
        clr(); iv = 1; il = 1; wr = 1; rd = 11;
        settle(); chk("second_long_stall", stall, 1); adv();
        done_v = 1; done_d = 32'h77;
        settle(); chk("second_long_ret_stall", stall, 1); adv();
        done_v = 0;
        settle(); chk("second_long_go", stall, 0); adv();
        clr(); done_v = 1; done_d = 32'h88;
        settle(); chk("second_long_busy", busy, 1); adv();

        // WAW on x9, independent instruction passes
        long_op(9);
        clr(); iv = 1; wr = 1; rd = 9;
        settle(); chk("waw_x9", stall, 1); adv();
        clr(); iv = 1; u1 = 1; rs1 = 1; u2 = 1; rs2 = 2; wr = 1; rd = 2;
        settle(); chk("indep_go", stall, 0); adv();
        clr(); done_v = 1; done_d = 32'h99;
        settle(); adv();

        // reset while in flight
        long_op(4);
        clr(); rst = 1;
        settle(); adv();
        clr(); iv = 1; u1 = 1; rs1 = 4; done_v = 1; done_d = 32'h44;
        settle(); chk("rst_x4_free", stall, 0); chk("rst_ready", ready, 0);
        chk("rst_ignored_we", rf_we, 0); adv();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            clr();
            rst    = ($urandom % 60) == 0;
            iv     = ($urandom % 4) != 0;
            u1     = $urandom % 2; rs1 = 5'($urandom % 8);
            u2     = $urandom % 2; rs2 = 5'($urandom % 8);
            wr     = ($urandom % 4) != 0; rd = 5'($urandom % 8);
            il     = ($urandom % 4) == 0;
            done_v = ($urandom % 3) == 0; done_d = $urandom;
            swe    = ($urandom % 3) == 0; sdata = $urandom;
            srd    = 5'($urandom % 8);
            if (pend[srd]) srd = 0;
            settle();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
